// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and iterative shifter.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2;
  localparam logic [2:0] AND = 3'b000, OR = 3'b001, SUB = 3'b010, ADD = 3'b011;
  localparam logic [2:0] SLL = 3'b100, SRA = 3'b101, SRL = 3'b110, SLT = 3'b111;

  logic [1:0] st_q, st_d;
  logic [2:0] op_q, op_d;
  logic [SHW-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic zero_q, neg_q, carry_q, ovf_q, carry_d, ovf_d;
  logic accept, is_shift;
  logic [2:0] sh_op;
  logic [WIDTH-1:0] sh_src, sh_res;
  logic [SHW-1:0] sh_rem, rem_n;
  logic [SHW:0] k;
  logic [WIDTH:0] sum, diff;

  assign in_ready = (st_q == IDLE) || (st_q == HOLD && out_ready);
  assign accept = in_valid && in_ready;
  assign is_shift = alu_sel[2] && alu_sel != SLT;
  assign out_valid = st_q == HOLD;
  assign alu_out = res_q;
  assign zero = zero_q;
  assign negative = neg_q;
  assign carry = carry_q;
  assign overflow = ovf_q;

  // SRA keeps the working MSB equal to the original sign, so >>> replicates it each step
  assign sh_op = accept ? alu_sel : op_q;
  assign sh_src = accept ? op_a : res_q;
  assign sh_rem = accept ? op_b[SHW-1:0] : rem_q;
  assign k = ({1'b0, sh_rem} >= STEP) ? STEP : {1'b0, sh_rem};
  assign rem_n = sh_rem - k[SHW-1:0];
  assign sh_res = sh_op == SLL ? sh_src << k
                : sh_op == SRA ? WIDTH'($unsigned($signed(sh_src) >>> k))
                : sh_src >> k;
  assign sum = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    st_d = st_q;
    op_d = op_q;
    rem_d = rem_q;
    res_d = res_q;
    carry_d = carry_q;
    ovf_d = ovf_q;
    if (accept) begin
      op_d = alu_sel;
      carry_d = 1'b0;
      ovf_d = 1'b0;
      rem_d = is_shift ? rem_n : '0;
      st_d = (is_shift && rem_n != 0) ? SHIFT : HOLD;
      case (alu_sel)
        AND: res_d = op_a & op_b;
        OR:  res_d = op_a | op_b;
        SUB: begin
          res_d = diff[WIDTH-1:0];
          carry_d = ~diff[WIDTH];
          ovf_d = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        end
        ADD: begin
          res_d = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
          ovf_d = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        end
        SLT: res_d = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
        default: res_d = sh_res;
      endcase
    end else if (st_q == SHIFT) begin
      res_d = sh_res;
      rem_d = rem_n;
      st_d = rem_n == 0 ? HOLD : SHIFT;
    end else if (st_q == HOLD && out_ready) begin
      st_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      op_q <= AND;
      rem_q <= '0;
      res_q <= '0;
      zero_q <= 1'b0;
      neg_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      st_q <= st_d;
      op_q <= op_d;
      rem_q <= rem_d;
      res_q <= res_d;
      zero_q <= res_d == 0;
      neg_q <= res_d[WIDTH-1];
      carry_q <= carry_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32, SHIFT_STEP=1).
module tb_alu_seq;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, zero, negative, carry, overflow;
  logic [2:0] alu_sel = 0;
  logic [31:0] op_a = 0, op_b = 0, alu_out;
  int tests = 0, fails = 0, lat;
  logic bad;

  alu_seq #(.WIDTH(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1;
    alu_sel = s;
    op_a = a;
    op_b = b;
    step();
    in_valid = 0;
    op_a = 32'hDEAD_BEEF;
    op_b = 32'h1234_5678;
  endtask

  task automatic wait_valid();
    lat = 1;
    bad = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) bad = 1;
      step();
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1;
    step();
    out_ready = 0;
    chk("drain_idle", {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, zero, negative, carry, overflow};
  endfunction

  initial begin
    step();
    step();
    rst = 0;
    chk("rst_hs", {30'd0, out_valid, in_ready}, 32'b01);
    chk("rst_out", alu_out, 32'h0);
    chk("rst_flags", flags(), 32'h0);

    issue(3'b011, 32'h7FFF_FFFF, 32'h1);
    chk("add_ovf_valid", {31'd0, out_valid}, 32'h1);
    chk("add_ovf_out", alu_out, 32'h8000_0000);
    chk("add_ovf_flags", flags(), 32'b0101);
    drain();

    issue(3'b011, 32'hFFFF_FFFF, 32'h1);
    chk("add_carry_out", alu_out, 32'h0);
    chk("add_carry_flags", flags(), 32'b1010);
    drain();

    issue(3'b010, 32'h2, 32'h2);
    chk("sub_eq_out", alu_out, 32'h0);
    chk("sub_eq_flags", flags(), 32'b1010);
    drain();

    issue(3'b010, 32'h1, 32'h2);
    chk("sub_neg_out", alu_out, 32'hFFFF_FFFF);
    chk("sub_neg_flags", flags(), 32'b0100);
    drain();

    issue(3'b010, 32'h8000_0000, 32'h1);
    chk("sub_ovf_out", alu_out, 32'h7FFF_FFFF);
    chk("sub_ovf_flags", flags(), 32'b0011);
    drain();

    issue(3'b101, 32'h8000_0000, 32'd31);
    wait_valid();
    chk("sra_lat", lat, 31);
    chk("sra_busy", {31'd0, bad}, 32'h0);
    chk("sra_out", alu_out, 32'hFFFF_FFFF);
    chk("sra_flags", flags(), 32'b0100);
    drain();

    issue(3'b100, 32'h1, 32'h25);
    wait_valid();
    chk("sll_lat", lat, 5);
    chk("sll_out", alu_out, 32'd32);
    drain();

    issue(3'b110, 32'h8000_0000, 32'h4);
    wait_valid();
    chk("srl_lat", lat, 4);
    chk("srl_out", alu_out, 32'h0800_0000);
    drain();

    issue(3'b101, 32'h8000_0000, 32'h20);
    chk("sra0_valid", {31'd0, out_valid}, 32'h1);
    chk("sra0_out", alu_out, 32'h8000_0000);
    chk("sra0_flags", flags(), 32'b0100);
    drain();

    out_ready = 1;
    in_valid = 1;
    alu_sel = 3'b000;
    op_a = 32'h17;
    op_b = 32'h0F;
    step();
    chk("b2b_and", alu_out, 32'h07);
    chk("b2b_ready", {31'd0, in_ready}, 32'h1);
    alu_sel = 3'b001;
    op_b = 32'h01;
    step();
    chk("b2b_or", alu_out, 32'h17);
    chk("b2b_or_valid", {31'd0, out_valid}, 32'h1);
    in_valid = 0;
    out_ready = 0;
    drain();

    issue(3'b000, 32'h17, 32'h0F);
    in_valid = 1;
    alu_sel = 3'b011;
    op_a = 32'h5;
    op_b = 32'h5;
    for (int i = 0; i < 3; i++) begin
      chk("stall_out", alu_out, 32'h07);
      chk("stall_hs", {30'd0, out_valid, in_ready}, 32'b10);
      step();
    end
    in_valid = 0;
    drain();

    issue(3'b111, 32'hFFFF_FFFF, 32'h1);
    chk("slt_lt_out", alu_out, 32'h1);
    chk("slt_lt_flags", flags(), 32'b0000);
    drain();

    issue(3'b111, 32'h1, 32'hFFFF_FFFF);
    chk("slt_ge_out", alu_out, 32'h0);
    chk("slt_ge_flags", flags(), 32'b1000);
    drain();

    issue(3'b100, 32'h1, 32'd20);
    step();
    step();
    chk("mid_shift_hs", {30'd0, out_valid, in_ready}, 32'b00);
    rst = 1;
    step();
    rst = 0;
    chk("midrst_hs", {30'd0, out_valid, in_ready}, 32'b01);
    chk("midrst_out", alu_out, 32'h0);
    issue(3'b011, 32'd10, 32'd5);
    chk("post_rst_valid", {31'd0, out_valid}, 32'h1);
    chk("post_rst_out", alu_out, 32'd15);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
